// File: rtl/jx2_mem_pkg.sv
// Shared definitions for the jx2 memory-tile responder.
//   - memOK status codes (READY/OK/HOLD/FAULT)
//   - memOpm field positions {WR, OE, Z0, S1, S0} and sub-word size codes
//   - line geometry and the canonical line-access opcodes
//   - responder FSM state encoding
package jx2_mem_pkg;

  localparam int LINE_W     = 128;
  localparam int LINE_BYTES = 16;

  localparam logic [1:0] UMEM_OK_READY = 2'd0;
  localparam logic [1:0] UMEM_OK_OK    = 2'd1;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;
  localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

  localparam int OPM_WR = 4;
  localparam int OPM_OE = 3;
  localparam int OPM_Z0 = 2;
  localparam int OPM_S1 = 1;
  localparam int OPM_S0 = 0;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_WORD  = 2'b01;
  localparam logic [1:0] SZ_DWORD = 2'b10;
  localparam logic [1:0] SZ_QWORD = 2'b11;

  // Low three opm bits all set marks a full-line access.
  localparam logic [2:0] OPM_LINE_SEL = 3'b111;

  localparam logic [4:0] OPM_LINE_RD   = 5'b01111;
  localparam logic [4:0] OPM_LINE_WR   = 5'b10111;
  localparam logic [4:0] OPM_LINE_SWAP = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } resp_state_t;

  // Number of bytes touched by a sub-word size code (1, 2, 4 or 8).
  function automatic logic [4:0] size_bytes(input logic [1:0] sz);
    return 5'd1 << sz;
  endfunction

  function automatic logic is_line_op(input logic [4:0] opm);
    return opm[2:0] == OPM_LINE_SEL;
  endfunction

endpackage

// File: rtl/jx2_mem_lane_sel.sv
// Sub-word lane selector for one 128-bit line (purely combinational).
// Ports:
//   line       in  128  current line contents
//   offset     in  4    starting byte within the line
//   size       in  2    size code: 00 byte, 01 word, 10 dword, 11 qword
//   zext       in  1    1 = zero-extend, 0 = sign-extend the load value
//   store_data in  64   store value, only the low 'size' bytes are used
//   load_val   out 64   extracted and extended load value
//   merged     out 128  line with the store bytes merged in
// Byte positions wrap modulo 16, so an access running past byte 15
// continues at byte 0 of the same line.
module jx2_mem_lane_sel
  import jx2_mem_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [3:0]        offset,
  input  logic [1:0]        size,
  input  logic              zext,
  input  logic [63:0]       store_data,
  output logic [63:0]       load_val,
  output logic [LINE_W-1:0] merged
);

  logic [4:0] nbytes;

  assign nbytes = size_bytes(size);

  always_comb begin
    logic [3:0] idx;
    logic       sign;
    load_val = '0;
    idx      = '0;
    sign     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = offset + 4'(i);
      if (5'(i) < nbytes) begin
        load_val[i*8 +: 8] = line[idx*8 +: 8];
        // Last in-range byte is the most significant one.
        sign = line[idx*8 + 7];
      end
    end
    if (!zext && sign) begin
      for (int i = 0; i < 8; i++) begin
        if (5'(i) >= nbytes) load_val[i*8 +: 8] = 8'hFF;
      end
    end
  end

  always_comb begin
    logic [3:0] rel;
    merged = line;
    rel    = '0;
    for (int j = 0; j < LINE_BYTES; j++) begin
      // Distance of line byte j from the start byte, modulo 16.
      rel = 4'(j) - offset;
      if ({1'b0, rel} < nbytes) merged[j*8 +: 8] = store_data[rel[2:0]*8 +: 8];
    end
  end

endmodule

// File: rtl/jx2_mem_tile_resp.sv
// Memory-side responder for the 128-bit line port of the data-cache tile.
// Backs line reads/writes/swaps and sub-word accesses with a
// 2^ADDR_BITS x 128-bit array, answering HOLD for LATENCY cycles then OK.
// Ports:
//   clock     in  1    rising-edge clock
//   reset     in  1    asynchronous, active-low reset
//   memAddr   in  48   byte address (line = [ADDR_BITS+3:4], offset = [3:0])
//   memOpm    in  5    {WR, OE, Z0, S1, S0}; 0 = no request
//   memDataI  in  128  store data (line, or sub-word in the low bits)
//   memDataO  out 128  load data (line, or extended value in [63:0])
//   memOK     out 2    0 READY, 1 OK, 2 HOLD, 3 FAULT
// Build option: define JX2_MEMTILE_RANGECHK_EN to fault accesses whose
// address bits above the array range are non-zero; otherwise those bits
// are ignored and addresses alias modulo the array size.
module jx2_mem_tile_resp
  import jx2_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [47:0]       memAddr,
  input  logic [4:0]        memOpm,
  input  logic [LINE_W-1:0] memDataI,
  output logic [LINE_W-1:0] memDataO,
  output logic [1:0]        memOK
);

  resp_state_t       state;
  logic [3:0]        cnt;
  logic [47:0]       addr_p0;
  logic [4:0]        opm_p0;
  logic [LINE_W-1:0] data_p0;

  logic [LINE_W-1:0] mem [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] line_idx;
  logic [LINE_W-1:0]    cur_line;
  logic [63:0]          sub_load;
  logic [LINE_W-1:0]    sub_merged;
  logic                 is_line;
  logic                 range_fault;
  logic                 access_now;
  logic                 do_write;
  logic [LINE_W-1:0]    new_line;
  logic [LINE_W-1:0]    rd_val;
  logic [LINE_W-1:0]    access_dout;
  logic [1:0]           access_status;
  logic                 start_req;
  logic                 restart_req;
  logic                 latch_req;

  // ---- request capture stage (_p0): latched address/opm/data ----
  assign start_req   = memOpm[OPM_WR] | memOpm[OPM_OE];
  // In DONE, only a changed opm or address counts as a new request;
  // the initiator holding its request steady just keeps seeing OK.
  assign restart_req = start_req && ((memOpm != opm_p0) || (memAddr != addr_p0));
  assign latch_req   = ((state == ST_IDLE) && start_req) ||
                       ((state == ST_DONE) && (memOpm != 5'd0) && restart_req);

  always_ff @(posedge clock) begin
    if (latch_req) data_p0 <= memDataI;
  end

  // ---- access stage: array read, lane select, write-back ----
  assign line_idx = addr_p0[ADDR_BITS+3:4];
  assign cur_line = mem[line_idx];
  assign is_line  = is_line_op(opm_p0);

  jx2_mem_lane_sel u_lane_sel (
    .line       (cur_line),
    .offset     (addr_p0[3:0]),
    .size       (opm_p0[OPM_S1:OPM_S0]),
    .zext       (opm_p0[OPM_Z0]),
    .store_data (data_p0[63:0]),
    .load_val   (sub_load),
    .merged     (sub_merged)
  );

`ifdef JX2_MEMTILE_RANGECHK_EN
  assign range_fault = (addr_p0 >> (ADDR_BITS + 4)) != 48'd0;
`else
  assign range_fault = 1'b0;
`endif

  assign access_now    = (state == ST_BUSY) && (cnt == 4'd1);
  assign do_write      = access_now && opm_p0[OPM_WR] && !range_fault;
  assign new_line      = is_line ? data_p0 : sub_merged;
  assign rd_val        = is_line ? cur_line : {64'd0, sub_load};
  // Swap returns the pre-write contents since cur_line is sampled before
  // the array update on the same edge.
  assign access_dout   = (opm_p0[OPM_OE] && !range_fault) ? rd_val : '0;
  assign access_status = range_fault ? UMEM_OK_FAULT : UMEM_OK_OK;

  // Array is never reset; a reset forces state to IDLE, which blocks do_write.
  always_ff @(posedge clock) begin
    if (do_write) mem[line_idx] <= new_line;
  end

  // ---- response stage: FSM and registered outputs ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      memOK    <= UMEM_OK_READY;
      memDataO <= '0;
      addr_p0  <= '0;
      opm_p0   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            addr_p0 <= memAddr;
            opm_p0  <= memOpm;
            cnt     <= 4'(LATENCY);
            memOK   <= UMEM_OK_HOLD;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd1) begin
            cnt      <= 4'd0;
            memOK    <= access_status;
            memDataO <= access_dout;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (memOpm == 5'd0) begin
            memOK <= UMEM_OK_READY;
            state <= ST_IDLE;
          end else if (restart_req) begin
            addr_p0 <= memAddr;
            opm_p0  <= memOpm;
            cnt     <= 4'(LATENCY);
            memOK   <= UMEM_OK_HOLD;
            state   <= ST_BUSY;
          end
        end
        default: begin
          memOK <= UMEM_OK_READY;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jx2_mem_tile_resp.sv
// Directed bench for jx2_mem_tile_resp with a scoreboard queue of expected
// responses and a byte-level reference model of the line array.
module tb_jx2_mem_tile_resp;

  localparam int AB  = 10;
  localparam int LAT = 2;

  localparam logic [1:0] S_READY = 2'd0;
  localparam logic [1:0] S_OK    = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic         clock;
  logic         reset;
  logic [47:0]  memAddr;
  logic [4:0]   memOpm;
  logic [127:0] memDataI;
  logic [127:0] memDataO;
  logic [1:0]   memOK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]   ok;
    logic [127:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] mdl [int];

  jx2_mem_tile_resp #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clock    (clock),
    .reset    (reset),
    .memAddr  (memAddr),
    .memOpm   (memOpm),
    .memDataI (memDataI),
    .memDataO (memDataO),
    .memOK    (memOK)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: byte-wise view of one access against mdl.
  task automatic model(input logic [4:0] opm, input logic [47:0] addr, input logic [127:0] din,
                       output logic [1:0] ok, output logic [127:0] dout);
    int           idx;
    int           off;
    int           n;
    logic [127:0] line;
    logic [63:0]  v;
    idx  = int'(addr[AB+3:4]);
    off  = int'(addr[3:0]);
    line = mdl.exists(idx) ? mdl[idx] : 128'd0;
    ok   = S_OK;
    dout = '0;
`ifdef JX2_MEMTILE_RANGECHK_EN
    if (addr[47:AB+4] != '0) begin
      ok = S_FAULT;
      return;
    end
`endif
    if (opm[2:0] == 3'b111) begin
      if (opm[3]) dout = line;
      if (opm[4]) mdl[idx] = din;
    end else begin
      case (opm[1:0])
        2'b00:   n = 1;
        2'b01:   n = 2;
        2'b10:   n = 4;
        default: n = 8;
      endcase
      v = '0;
      for (int b = 0; b < n; b++) v[b*8 +: 8] = line[((off + b) % 16)*8 +: 8];
      if (!opm[2] && n < 8 && v[8*n-1])
        for (int b = n; b < 8; b++) v[b*8 +: 8] = 8'hFF;
      if (opm[3]) dout = {64'd0, v};
      if (opm[4]) begin
        for (int b = 0; b < n; b++) line[((off + b) % 16)*8 +: 8] = din[b*8 +: 8];
        mdl[idx] = line;
      end
    end
  endtask

  // Issue one request, expect LAT HOLD cycles, then compare against the
  // scoreboard; optionally drop the request and expect READY.
  task automatic access(input string tag, input logic [4:0] opm, input logic [47:0] addr,
                        input logic [127:0] din, input bit release_req,
                        output logic [127:0] got);
    exp_t e;
    int   holds;
    bit   done;
    model(opm, addr, din, e.ok, e.data);
    sb.push_back(e);
    memOpm   = opm;
    memAddr  = addr;
    memDataI = din;
    holds    = 0;
    done     = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clock); #1;
      if (memOK === S_HOLD) holds++;
      else done = 1'b1;
    end
    chk({tag, "_done"}, 128'(done), 128'd1);
    chk({tag, "_holds"}, 128'(holds), 128'(LAT));
    e = sb.pop_front();
    chk({tag, "_status"}, 128'(memOK), 128'(e.ok));
    chk({tag, "_data"}, memDataO, e.data);
    got = memDataO;
    if (release_req) begin
      memOpm = 5'd0;
      @(posedge clock); #1;
      chk({tag, "_ready"}, 128'(memOK), 128'(S_READY));
    end
  endtask

  localparam logic [127:0] LINE_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] LINE_M = 128'h00112233_44556677_DEADBEEF_CCDDEEFF;
  localparam logic [127:0] LINE_S = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  initial begin
    logic [127:0] got;
    logic [4:0]   opm;
    logic [47:0]  addr;
    reset    = 1'b0;
    memOpm   = 5'd0;
    memAddr  = '0;
    memDataI = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_status", 128'(memOK), 128'(S_READY));
    chk("reset_data", memDataO, 128'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("idle_status", 128'(memOK), 128'(S_READY));

    // Line write then read back.
    access("line_wr", 5'b10111, 48'h40, LINE_A, 1'b1, got);
    chk("line_wr_zero", got, 128'd0);
    access("line_rd", 5'b01111, 48'h40, '0, 1'b1, got);
    chk("line_rd_val", got, LINE_A);

    // Byte reads, sign- then zero-extended.
    access("byte_s", 5'b01000, 48'h40, '0, 1'b1, got);
    chk("byte_s_val", got, 128'hFFFFFFFF_FFFFFFFF);
    access("byte_z", 5'b01100, 48'h40, '0, 1'b1, got);
    chk("byte_z_val", got, 128'hFF);

    // Dword store merge, then line read left in DONE.
    access("dw_st", 5'b10010, 48'h44, 128'hDEADBEEF, 1'b1, got);
    access("merge_rd", 5'b01111, 48'h40, '0, 1'b0, got);
    chk("merge_rd_val", got, LINE_M);

    // Held request in DONE stays OK with stable data.
    @(posedge clock); #1;
    chk("done_hold_status", 128'(memOK), 128'(S_OK));
    chk("done_hold_data", memDataO, LINE_M);

    // Back-to-back: new opm while in DONE, wrapping qword read.
    access("qw_wrap", 5'b01011, 48'h4C, '0, 1'b1, got);
    chk("qw_wrap_val", got, 128'hCCDDEEFF_00112233);

    // Swap returns old line, stores new.
    access("swap", 5'b11111, 48'h40, LINE_S, 1'b1, got);
    chk("swap_old", got, LINE_M);
    // Word sign read spanning byte 15 -> byte 0: bytes 0F then F0.
    access("word_wrap", 5'b01001, 48'h4F, '0, 1'b1, got);
    chk("word_wrap_val", got, 128'hFFFFFFFF_FFFFF00F);

    // Mixed sub-word traffic on a second line checked against the model.
    access("l80_init", 5'b10111, 48'h80, LINE_A, 1'b1, got);
    for (int i = 0; i < 10; i++) begin
      opm = 5'($urandom_range(0, 31));
      if (opm[4:3] == 2'b00) opm[3] = 1'b1;
      if (opm[2:0] == 3'b111) opm[2] = 1'b0;
      addr = 48'h80 + 48'($urandom_range(0, 15));
      access($sformatf("sub%0d", i), opm, addr,
             {$urandom, $urandom, $urandom, $urandom}, (i % 3) != 0, got);
    end
    memOpm = 5'd0;
    @(posedge clock); #1;
    access("l80_final", 5'b01111, 48'h80, '0, 1'b1, got);

    // Reset during BUSY of a write: nothing is committed.
    memOpm   = 5'b10111;
    memAddr  = 48'h40;
    memDataI = {4{32'hA5A5A5A5}};
    @(posedge clock); #1;
    chk("abort_busy", 128'(memOK), 128'(S_HOLD));
    reset = 1'b0;
    #1;
    chk("abort_status", 128'(memOK), 128'(S_READY));
    chk("abort_data", memDataO, 128'd0);
    memOpm = 5'd0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    access("after_abort", 5'b01111, 48'h40, '0, 1'b1, got);
    chk("after_abort_val", got, LINE_S);

    // Upper address bits: FAULT with range check, alias to 0x40 without.
    access("range_rd", 5'b01111, 48'h0001_0040, '0, 1'b1, got);
`ifdef JX2_MEMTILE_RANGECHK_EN
    chk("range_rd_zero", got, 128'd0);
    access("range_wr", 5'b10111, 48'h0001_0040, {4{32'h12345678}}, 1'b1, got);
    access("range_after", 5'b01111, 48'h40, '0, 1'b1, got);
    chk("range_after_val", got, LINE_S);
`else
    chk("alias_val", got, LINE_S);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
